// File: rtl/pipe_pkg.sv
// Shared types for the hazard/forwarding shadow pipeline.
// Holds the per-stage destination metadata record, the hazard FSM
// encoding and the default register-number width.
package pipe_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  // FSM encoding: RUN = normal issue, MC_BUSY = multi-cycle op owns EX
  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MC_BUSY = 1'b1;

  // Destination-register metadata carried through EX, MEM and WB
  typedef struct packed {
    logic                      valid;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic                      regwrite;
    logic                      memread;
  } stage_t;

  // A stage really writes the register file only when it is valid,
  // asserts regwrite and does not target $zero.
  function automatic logic eff_we(input stage_t s);
    return s.valid & s.regwrite & (s.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow stage register of destination metadata.
// clear has priority over hold; with neither asserted the stage loads d.
module hazard_stage_reg
  import pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   clear,
  input  stage_t d,
  output stage_t q
);

  // Stage update: clear to an empty slot, keep, or advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= '0;
    else if (clear)  q <= '0;
    else if (!hold)  q <= d;
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Hazard detection unit beside the ID stage of a 5-stage MIPS pipeline.
// Tracks EX/MEM/WB destination metadata for the forwarding logic, stalls
// on load-use, holds the front end while a multi-cycle op owns EX, and
// flushes IF/ID + ID/EX on a taken branch.
// Optional: define HAZARD_PERF_CNT_EN to add saturating event counters
// (StallCycles, FlushCount, McBusyCycles).
// REG_ADDR_W must match pipe_pkg::DEF_REG_ADDR_W (the stage record uses it).
module hazard_detection_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MC_LATENCY = 4
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ID_Valid,
  input  logic [REG_ADDR_W-1:0] ID_RegisterRs,
  input  logic [REG_ADDR_W-1:0] ID_RegisterRt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] ID_RegisterRd,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_MultiCycle,
  input  logic                  EX_BranchTaken,
  output logic                  PC_Write,
  output logic                  IFID_Write,
  output logic                  IFID_Flush,
  output logic                  IDEX_Bubble,
  output logic                  EX_Hold,
  output logic [REG_ADDR_W-1:0] MEM_RegisterRd,
  output logic                  MEM_RegWrite,
  output logic [REG_ADDR_W-1:0] WB_RegisterRd,
  output logic                  WB_RegWrite
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      StallCycles,
  output logic [CNT_W-1:0]      FlushCount,
  output logic [CNT_W-1:0]      McBusyCycles
`endif
);

  // Counter preload: the entry edge already counts as the first EX cycle,
  // so the front end is held for MC_LATENCY-1 further cycles.
  localparam logic [3:0] MC_INIT = 4'(MC_LATENCY - 1);

  logic [0:0] state;
  logic [3:0] cnt;

  stage_t ex_q, mem_q, wb_q, id_d;

  logic run, busy, mc_exit;
  logic ld_use, flush, stall, bubble, mc_start;
  logic ex_hold, ex_clr, mem_clr;

  assign run     = (state == RUN);
  assign busy    = (state == MC_BUSY);
  assign mc_exit = busy && (cnt == 4'd1);

  // ID fields as they would enter EX
  always_comb begin
    id_d          = '0;
    id_d.valid    = ID_Valid;
    id_d.rd       = ID_RegisterRd;
    id_d.regwrite = ID_RegWrite;
    id_d.memread  = ID_MemRead;
  end

  // Hazard decode: load-use stall, branch flush, multi-cycle entry
  always_comb begin
    ld_use = run & ID_Valid & ex_q.memread & eff_we(ex_q) &
             ((ID_UsesRs & (ex_q.rd == ID_RegisterRs)) |
              (ID_UsesRt & (ex_q.rd == ID_RegisterRt)));
    flush    = run & EX_BranchTaken;
    // a squashed ID instruction cannot stall anything
    stall    = ld_use & ~flush;
    bubble   = flush | stall;
    mc_start = run & ID_Valid & ID_MultiCycle & ~bubble;
  end

  // Pipeline control outputs
  always_comb begin
    PC_Write    = run & ~stall;
    IFID_Write  = run & ~stall;
    IFID_Flush  = flush;
    IDEX_Bubble = bubble;
    EX_Hold     = busy;
  end

  // Stage steering: EX freezes during MC_BUSY and empties on exit (the ID
  // instruction was held, so it enters EX on the following RUN edge);
  // MEM sees bubbles while EX is occupied, then takes the finished op.
  always_comb begin
    ex_hold = busy & ~mc_exit;
    ex_clr  = (run & bubble) | mc_exit;
    mem_clr = busy & ~mc_exit;
  end

  hazard_stage_reg u_ex (
    .clk   (clk_i),
    .rst   (rst_i),
    .hold  (ex_hold),
    .clear (ex_clr),
    .d     (id_d),
    .q     (ex_q)
  );

  hazard_stage_reg u_mem (
    .clk   (clk_i),
    .rst   (rst_i),
    .hold  (1'b0),
    .clear (mem_clr),
    .d     (ex_q),
    .q     (mem_q)
  );

  hazard_stage_reg u_wb (
    .clk   (clk_i),
    .rst   (rst_i),
    .hold  (1'b0),
    .clear (1'b0),
    .d     (mem_q),
    .q     (wb_q)
  );

  // Multi-cycle FSM and EX occupancy counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
      cnt   <= '0;
    end else if (run) begin
      if (mc_start) begin
        state <= MC_BUSY;
        cnt   <= MC_INIT;
      end
    end else begin
      if (mc_exit) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Forwarding-side view of the shadow MEM/WB stages
  always_comb begin
    MEM_RegisterRd = mem_q.rd;
    MEM_RegWrite   = eff_we(mem_q);
    WB_RegisterRd  = wb_q.rd;
    WB_RegWrite    = eff_we(wb_q);
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      StallCycles  <= '0;
      FlushCount   <= '0;
      McBusyCycles <= '0;
    end else begin
      if (stall && !(&StallCycles))   StallCycles  <= StallCycles + 1'b1;
      if (flush && !(&FlushCount))    FlushCount   <= FlushCount + 1'b1;
      if (busy && !(&McBusyCycles))   McBusyCycles <= McBusyCycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed self-checking bench for hazard_detection_unit (MC_LATENCY=4).
module tb_hazard_detection_unit;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       ID_Valid, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead;
  logic       ID_MultiCycle, EX_BranchTaken;
  logic [4:0] ID_RegisterRs, ID_RegisterRt, ID_RegisterRd;
  logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EX_Hold;
  logic [4:0] MEM_RegisterRd, WB_RegisterRd;
  logic       MEM_RegWrite, WB_RegWrite;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles, FlushCount, McBusyCycles;
`endif

  int errors = 0;
  int checks = 0;

  hazard_detection_unit #(.REG_ADDR_W(5), .MC_LATENCY(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ID_Valid       (ID_Valid),
    .ID_RegisterRs  (ID_RegisterRs),
    .ID_RegisterRt  (ID_RegisterRt),
    .ID_UsesRs      (ID_UsesRs),
    .ID_UsesRt      (ID_UsesRt),
    .ID_RegisterRd  (ID_RegisterRd),
    .ID_RegWrite    (ID_RegWrite),
    .ID_MemRead     (ID_MemRead),
    .ID_MultiCycle  (ID_MultiCycle),
    .EX_BranchTaken (EX_BranchTaken),
    .PC_Write       (PC_Write),
    .IFID_Write     (IFID_Write),
    .IFID_Flush     (IFID_Flush),
    .IDEX_Bubble    (IDEX_Bubble),
    .EX_Hold        (EX_Hold),
    .MEM_RegisterRd (MEM_RegisterRd),
    .MEM_RegWrite   (MEM_RegWrite),
    .WB_RegisterRd  (WB_RegisterRd),
    .WB_RegWrite    (WB_RegWrite)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCycles    (StallCycles),
    .FlushCount     (FlushCount),
    .McBusyCycles   (McBusyCycles)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mc);
    ID_Valid = v; ID_RegisterRs = rs; ID_RegisterRt = rt;
    ID_UsesRs = urs; ID_UsesRt = urt; ID_RegisterRd = rd;
    ID_RegWrite = rw; ID_MemRead = mr; ID_MultiCycle = mc;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    EX_BranchTaken = 1'b0;
    idle();
    #12;
    chk("rst_pc_write",   PC_Write,     1);
    chk("rst_ifid_write", IFID_Write,   1);
    chk("rst_ifid_flush", IFID_Flush,   0);
    chk("rst_bubble",     IDEX_Bubble,  0);
    chk("rst_ex_hold",    EX_Hold,      0);
    chk("rst_mem_rw",     MEM_RegWrite, 0);
    chk("rst_mem_rd",     MEM_RegisterRd, 0);
    chk("rst_wb_rw",      WB_RegWrite,  0);
    rst_i = 1'b0;
    tick();

    // load-use: lw $2 then add reading $2
    set_id(1, 1, 0, 1, 0, 2, 1, 1, 0);
    #1 chk("lw_issue_pc", PC_Write, 1);
    tick();
    set_id(1, 2, 3, 1, 1, 3, 1, 0, 0);
    #1;
    chk("lu_pc_write",   PC_Write,    0);
    chk("lu_ifid_write", IFID_Write,  0);
    chk("lu_bubble",     IDEX_Bubble, 1);
    chk("lu_no_flush",   IFID_Flush,  0);
    tick();
    chk("lu_mem_rd",     MEM_RegisterRd, 2);
    chk("lu_mem_rw",     MEM_RegWrite,   1);
    chk("lu_no_restall", PC_Write,       1);
    chk("lu_no_bubble2", IDEX_Bubble,    0);
    tick();
    chk("lu_wb_rd", WB_RegisterRd, 2);
    chk("lu_wb_rw", WB_RegWrite,   1);

    // load to $zero never stalls and never writes
    set_id(1, 1, 0, 1, 0, 0, 1, 1, 0);
    tick();
    set_id(1, 0, 0, 1, 0, 4, 0, 0, 0);
    #1;
    chk("z_pc_write", PC_Write,    1);
    chk("z_bubble",   IDEX_Bubble, 0);
    tick();
    chk("z_mem_rw", MEM_RegWrite,   0);
    chk("z_mem_rd", MEM_RegisterRd, 0);

    // multi-cycle mult to $5 holds the front end for 3 cycles
    idle();
    tick();
    set_id(1, 3, 4, 1, 1, 5, 1, 0, 1);
    #1 chk("mc_pre_hold", EX_Hold, 0);
    tick();
    set_id(1, 7, 8, 1, 1, 6, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mc_hold%0d", i),   EX_Hold,      1);
      chk($sformatf("mc_mem_rw%0d", i), MEM_RegWrite, 0);
      chk($sformatf("mc_pc%0d", i),     PC_Write,     0);
      tick();
    end
    chk("mc_done_hold", EX_Hold,        0);
    chk("mc_mem_rd",    MEM_RegisterRd, 5);
    chk("mc_mem_rw",    MEM_RegWrite,   1);
    chk("mc_pc_resume", PC_Write,       1);
    tick();
    idle();
    chk("mc_gap_rw", MEM_RegWrite, 0);
    tick();
    chk("mc_next_rd", MEM_RegisterRd, 6);
    chk("mc_next_rw", MEM_RegWrite,   1);

    // branch flush wins over a simultaneous load-use
    set_id(1, 1, 0, 1, 0, 7, 1, 1, 0);
    tick();
    set_id(1, 7, 0, 1, 0, 8, 1, 0, 0);
    EX_BranchTaken = 1'b1;
    #1;
    chk("fl_flush",      IFID_Flush,  1);
    chk("fl_bubble",     IDEX_Bubble, 1);
    chk("fl_pc_write",   PC_Write,    1);
    chk("fl_ifid_write", IFID_Write,  1);
    tick();
    EX_BranchTaken = 1'b0;
    set_id(1, 7, 0, 1, 0, 9, 1, 0, 0);
    #1;
    chk("fl_no_stall", PC_Write,       1);
    chk("fl_bubble0",  IDEX_Bubble,    0);
    chk("fl_mem_rd",   MEM_RegisterRd, 7);
    tick();

    // flush squashes a multi-cycle op in ID
    set_id(1, 1, 2, 1, 1, 11, 1, 0, 1);
    EX_BranchTaken = 1'b1;
    tick();
    EX_BranchTaken = 1'b0;
    idle();
    #1;
    chk("sq_no_hold", EX_Hold,  0);
    chk("sq_pc",      PC_Write, 1);

    // asynchronous reset in the second MC_BUSY cycle
    tick();
    set_id(1, 1, 2, 1, 1, 9, 1, 0, 1);
    tick();
    set_id(1, 9, 0, 1, 0, 10, 1, 0, 0);
    tick();
    chk("rb_busy", EX_Hold, 1);
    rst_i = 1'b1;
    #1;
    chk("rb_hold",   EX_Hold,        0);
    chk("rb_pc",     PC_Write,       1);
    chk("rb_ifid",   IFID_Write,     1);
    chk("rb_mem_rw", MEM_RegWrite,   0);
    chk("rb_mem_rd", MEM_RegisterRd, 0);
    chk("rb_wb_rw",  WB_RegWrite,    0);
    chk("rb_wb_rd",  WB_RegisterRd,  0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rb_stall_cnt", StallCycles,  0);
    chk("rb_flush_cnt", FlushCount,   0);
    chk("rb_busy_cnt",  McBusyCycles, 0);
`endif
    #1 rst_i = 1'b0;
    tick();
    #1;
    chk("ra_pc",     PC_Write,    1);
    chk("ra_bubble", IDEX_Bubble, 0);
    chk("ra_hold",   EX_Hold,     0);
    tick();
    idle();
    tick();
    chk("ra_mem_rd", MEM_RegisterRd, 10);
    chk("ra_mem_rw", MEM_RegWrite,   1);

`ifdef HAZARD_PERF_CNT_EN
    // two load-use stalls and one flush
    set_id(1, 1, 0, 1, 0, 12, 1, 1, 0);
    tick();
    set_id(1, 12, 0, 1, 0, 13, 1, 0, 0);
    tick();
    tick();
    set_id(1, 1, 0, 1, 0, 14, 1, 1, 0);
    tick();
    set_id(1, 0, 14, 0, 1, 15, 1, 0, 0);
    tick();
    tick();
    idle();
    EX_BranchTaken = 1'b1;
    tick();
    EX_BranchTaken = 1'b0;
    chk("pc_stall_cnt", StallCycles,  2);
    chk("pc_flush_cnt", FlushCount,   1);
    chk("pc_busy_cnt",  McBusyCycles, 0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
